led_share_arbiter: RTL
======================

Name: led_share_arbiter

Overview:
Shares the 8-bit board LED bank between NUM_REQ independent pattern sources, such as the free-running counter display, status flags and debug taps. Arbitration is round-robin, and each winner holds the LEDs for a fixed time measured in prescaler ticks. A requester can release the LEDs early by dropping its request. The block sits between the pattern generators and the top-level leds output, replacing the direct counter-to-LED connection.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
TICK_DIV, 12_000_000, clk cycles per prescaler tick; must be >= 1.
HOLD_TICKS, 4, ticks a grant is held before forced release; must be >= 1.
IDLE_PATTERN, 8'h00, LED value driven when no requester is granted.

Ports:
clk  in  1  system clock.
rst  in  1  reset: synchronous, active-high.
req  in  NUM_REQ  request vector; bit i is held high while requester i wants the LEDs.
pattern  in  8*NUM_REQ  pattern of requester i is pattern[8*i+7:8*i].
grant  out  NUM_REQ  one-hot registered grant; all zero when nobody is granted.
done  out  NUM_REQ  one-cycle pulse on bit i when requester i's hold time expires.
leds  out  8  registered LED drive.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE, grant 0, done 0, leds IDLE_PATTERN, busy 0, prescaler 0, tick count 0, last_winner NUM_REQ-1. Because last_winner resets to NUM_REQ-1, requester 0 has first priority after reset.
- Reset mid-operation: the next edge reinstates all reset values. The current grant is dropped without a done pulse.
- States are IDLE, SHOW and GAP.
- IDLE:
  - If any req bit is high at an edge, the winner is the first set bit scanning last_winner+1, last_winner+2, ... with wrap-around modulo NUM_REQ.
  - At that same edge: state becomes SHOW, grant becomes onehot(winner), last_winner becomes winner, prescaler and tick count clear to 0.
  - Arbitration latency is 1 cycle from req sampled high to grant high.
  - If no req bit is high, the block stays in IDLE.
- SHOW:
  - The prescaler counts 0..TICK_DIV-1 and wraps; a tick occurs in the cycle where it equals TICK_DIV-1.
  - The tick count increments on each tick.
  - Timeout: if a tick occurs while tick count equals HOLD_TICKS-1, the next state is GAP. grant is high for exactly HOLD_TICKS*TICK_DIV cycles.
  - Early release: if req[winner] is sampled low in any SHOW cycle, the next state is GAP and no done pulse is produced.
  - If early release and timeout fall on the same edge, early release wins and done stays 0.
  - Other req bits changing during SHOW have no effect; there is no preemption.
- GAP:
  - Lasts exactly 1 cycle. grant is 0 and leds is IDLE_PATTERN.
  - done[winner] is 1 only if the entry to GAP was caused by timeout.
  - The next state is always IDLE.
  - Minimum spacing between consecutive grants is therefore 2 cycles of grant low: GAP plus IDLE.
- leds is a register:
  - If the next state is SHOW, leds loads pattern[winner] as sampled at that edge; otherwise it loads IDLE_PATTERN.
  - Result: in every cycle where grant[i] is high, leds equals pattern[i] from the previous cycle.
  - Pattern changes during SHOW therefore appear with 1 cycle of latency.
- busy is registered and equals (state != IDLE).
- done and grant are never high at the same time. At most one grant bit is ever set.
- Counter widths: prescaler is clog2(TICK_DIV) bits, or 1 bit minimum; tick count is clog2(HOLD_TICKS)+1 bits. Neither counter overflows.

Test Plan:
All scenarios use NUM_REQ=4, TICK_DIV=3, HOLD_TICKS=2, IDLE_PATTERN=8'h00, so a full SHOW lasts 6 cycles.
1. Reset: hold rst 3 cycles with random req -> grant=0, done=0, leds=8'h00, busy=0 throughout, and 1 cycle after rst falls.
2. Single requester: req=4'b0100 from cycle 0, pattern2=8'hA5 -> grant=4'b0100 for cycles 1-6, leds=8'hA5 for cycles 1-6, done=4'b0100 in cycle 7 only, grant re-asserts in cycle 9.
3. Round-robin fairness: req=4'b1111 held -> grant sequence 0,1,2,3,0, each held 6 cycles, with a done pulse after each grant.
4. Early release: req=4'b0010, then drop req[1] in SHOW cycle 3 -> grant low from cycle 4, done stays 0, state returns to IDLE at cycle 5.
5. Reset mid-SHOW: requester 2 granted, assert rst in SHOW cycle 2 -> next cycle grant=0, done=0, leds=8'h00; with req=4'b0101 afterwards, requester 0 wins first.
6. Pattern tracking: requester 3 granted, pattern3 steps 8'h01 -> 8'h02 -> 8'h04 on consecutive cycles -> leds shows 8'h01, 8'h02, 8'h04 one cycle later each.

Source files
------------

// File: rtl/led_share_arbiter_if.sv
// LED-bank sharing bus: request/pattern vectors from the pattern sources,
// grant/done/LED drive back from the arbiter.
interface led_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] pattern;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           leds;
  logic                 busy;

  // Pattern-source side
  modport master (
    output req, pattern,
    input  grant, done, leds, busy
  );

  // Arbiter side
  modport slave (
    input  req, pattern,
    output grant, done, leds, busy
  );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the 8-bit LED bank. Each winner drives the LEDs for
// HOLD_TICKS prescaler ticks unless it drops its request first; every grant
// is followed by a one-cycle GAP and an IDLE cycle before the next one.
module led_share_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          TICK_DIV     = 12_000_000,
  parameter int          HOLD_TICKS   = 4,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  led_share_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TCK_W = $clog2(HOLD_TICKS) + 1;

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TCK_W-1:0]   TCK_LAST = TCK_W'(HOLD_TICKS - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [7:0]         r_leds;
  logic               r_busy;
  logic [PRE_W-1:0]   r_pre;
  logic [TCK_W-1:0]   r_ticks;
  logic [IDX_W-1:0]   r_last;

  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_win;
  logic               w_any;
  logic [7:0]         w_win_pat;
  logic [7:0]         w_cur_pat;
  logic               w_tick;
  logic               w_timeout;
  logic               w_held;

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.leds  = r_leds;
  assign bus.busy  = r_busy;

  // Round-robin pick: first set request after last winner, with wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the unassigned paths infer latches.
    w_idx = r_last;
    w_win = r_last;
    w_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == IDX_LAST) ? '0 : w_idx + IDX_W'(1);
      if (!w_any && bus.req[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  // Pattern muxes: new winner's pattern and current owner's pattern.
  always_comb begin
    w_win_pat = IDLE_PATTERN;
    w_cur_pat = IDLE_PATTERN;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i))  w_win_pat = bus.pattern[8*i +: 8];
      if (r_last == IDX_W'(i)) w_cur_pat = bus.pattern[8*i +: 8];
    end
  end

  assign w_tick    = (r_pre == PRE_LAST);
  assign w_timeout = w_tick && (r_ticks == TCK_LAST);
  assign w_held    = bus.req[r_last];

  // Arbitration FSM with registered grant/done/leds/busy.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_leds  <= IDLE_PATTERN;
      r_busy  <= 1'b0;
      r_pre   <= '0;
      r_ticks <= '0;
      r_last  <= IDX_LAST;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_SHOW;
            r_grant <= ONE << w_win;
            r_last  <= w_win;
            r_pre   <= '0;
            r_ticks <= '0;
            r_leds  <= w_win_pat;
            r_busy  <= 1'b1;
          end else begin
            r_grant <= '0;
            r_leds  <= IDLE_PATTERN;
            r_busy  <= 1'b0;
          end
        end

        S_SHOW: begin
          if (!w_held) begin
            // Early release takes precedence over a coincident timeout.
            r_state <= S_GAP;
            r_grant <= '0;
            r_leds  <= IDLE_PATTERN;
            r_busy  <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_GAP;
            r_grant <= '0;
            r_done  <= ONE << r_last;
            r_leds  <= IDLE_PATTERN;
            r_busy  <= 1'b1;
          end else begin
            r_pre  <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) r_ticks <= r_ticks + TCK_W'(1);
            r_leds <= w_cur_pat;
            r_busy <= 1'b1;
          end
        end

        S_GAP: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_leds  <= IDLE_PATTERN;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_leds  <= IDLE_PATTERN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
